// File: rtl/riscv_crypto_sha256_msched_pkg.sv
// -----------------------------------------------------------------------------
// riscv_crypto_pkg
// Shared definitions for the SHA-256 message-schedule controller:
//   - SHA-256 block/round constants
//   - controller state encoding
//   - operation select for the shared SHA-256 sigma/sum functional unit
//   - small helpers used by the datapath
// -----------------------------------------------------------------------------
package riscv_crypto_pkg;

    localparam int SHA256_BLK_WORDS = 16;
    localparam int SHA256_ROUNDS    = 64;
    localparam int SHA256_IDX_W     = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SIG0,
        ST_SIG1,
        ST_OUT
    } msched_state_e;

    typedef enum logic [1:0] {
        SSHA_SIG0,
        SSHA_SIG1,
        SSHA_SUM0,
        SSHA_SUM1
    } ssha256_op_e;

    // Circular-buffer slot of W[t-back]; the 4-bit subtraction wraps mod 16.
    function automatic logic [3:0] blk_slot(input logic [5:0] t, input logic [3:0] back);
        return t[3:0] - back;
    endfunction

    // Rotate right by a constant amount.
    function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

// File: rtl/riscv_crypto_sha256_msched_if.sv
// -----------------------------------------------------------------------------
// riscv_crypto_sha256_msched_if
// Handshake bundle of the SHA-256 message-schedule controller.
//   start/abort         : block control (from requester)
//   in_valid/in_ready   : message-word input handshake, in_word = W[0..15]
//   out_valid/out_ready : schedule-word output handshake, out_word = W[out_idx]
//   busy/done           : status (busy = not idle, done = end-of-block pulse)
// modport master : requester / consumer side
// modport slave  : controller side
// -----------------------------------------------------------------------------
interface riscv_crypto_sha256_msched_if import riscv_crypto_pkg::*; ();

    logic                    start;
    logic                    abort;
    logic                    in_valid;
    logic                    in_ready;
    logic [31:0]             in_word;
    logic                    out_valid;
    logic                    out_ready;
    logic [31:0]             out_word;
    logic [SHA256_IDX_W-1:0] out_idx;
    logic                    busy;
    logic                    done;

    modport master (
        output start, abort, in_valid, in_word, out_ready,
        input  in_ready, out_valid, out_word, out_idx, busy, done
    );

    modport slave (
        input  start, abort, in_valid, in_word, out_ready,
        output in_ready, out_valid, out_word, out_idx, busy, done
    );

endinterface

// File: rtl/riscv_crypto_sha256_msched_ssha256.sv
// -----------------------------------------------------------------------------
// riscv_crypto_fu_ssha256
// Combinational SHA-256 sigma/sum unit (the four RISC-V sha256 functions).
//   op  in  : function select (sig0, sig1, sum0, sum1), exactly one per cycle
//   rs1 in  : 32-bit operand
//   rd  out : 32-bit result
// -----------------------------------------------------------------------------
module riscv_crypto_fu_ssha256
    import riscv_crypto_pkg::*;
(
    input  ssha256_op_e op,
    input  logic [31:0] rs1,
    output logic [31:0] rd
);

    logic [31:0] sig0_res;
    logic [31:0] sig1_res;
    logic [31:0] sum0_res;
    logic [31:0] sum1_res;

    assign sig0_res = ror32(rs1, 7)  ^ ror32(rs1, 18) ^ (rs1 >> 3);
    assign sig1_res = ror32(rs1, 17) ^ ror32(rs1, 19) ^ (rs1 >> 10);
    assign sum0_res = ror32(rs1, 2)  ^ ror32(rs1, 13) ^ ror32(rs1, 22);
    assign sum1_res = ror32(rs1, 6)  ^ ror32(rs1, 11) ^ ror32(rs1, 25);

    always_comb begin
        rd = sig0_res;
        unique case (op)
            SSHA_SIG0: rd = sig0_res;
            SSHA_SIG1: rd = sig1_res;
            SSHA_SUM0: rd = sum0_res;
            SSHA_SUM1: rd = sum1_res;
            default:   rd = sig0_res;
        endcase
    end

endmodule

// File: rtl/riscv_crypto_sha256_msched.sv
// -----------------------------------------------------------------------------
// riscv_crypto_sha256_msched
// SHA-256 message-schedule generator. Accepts the 16 message words of a block
// and emits W[0..ROUNDS-1] one at a time. W[0..15] come straight from the
// 16-entry circular buffer; each later word takes three cycles (OUT, SIG0,
// SIG1) because a single sigma unit is shared between sig0 and sig1.
//   g_clk    in : clock, rising edge
//   g_resetn in : asynchronous active-low reset
//   bus         : handshake bundle (slave modport), see the interface file
// Parameter ROUNDS : number of schedule words per block, 17..64.
// -----------------------------------------------------------------------------
module riscv_crypto_sha256_msched
    import riscv_crypto_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS
) (
    input  logic                         g_clk,
    input  logic                         g_resetn,
    riscv_crypto_sha256_msched_if.slave  bus
);

    localparam logic [5:0] LAST_T   = 6'(ROUNDS - 1);
    localparam logic [5:0] LAST_BLK = 6'(SHA256_BLK_WORDS - 1);

    msched_state_e state_reg, state_next;
    logic [5:0]    t_reg, t_next;
    logic [31:0]   tmp_reg, tmp_next;
    logic [31:0]   out_word_reg, out_word_next;
    logic          done_reg, done_next;

    // Circular buffer of the last 16 schedule words; slot t mod 16 holds W[t]
    // once written. Every slot is filled during LOAD before it is read, so it
    // carries no reset.
    logic [31:0]   buf_mem [SHA256_BLK_WORDS];
    logic          buf_we;
    logic [3:0]    buf_waddr;
    logic [31:0]   buf_wdata;

    ssha256_op_e   sig_op;
    logic [31:0]   sig_rs1;
    logic [31:0]   sig_rd;
    logic [31:0]   w_new;

    riscv_crypto_fu_ssha256 u_ssha256 (
        .op  (sig_op),
        .rs1 (sig_rs1),
        .rd  (sig_rd)
    );

    // Operand steering for the shared unit; zero operand when not in use.
    always_comb begin
        sig_op  = SSHA_SIG0;
        sig_rs1 = '0;
        if (state_reg == ST_SIG0) begin
            sig_op  = SSHA_SIG0;
            sig_rs1 = buf_mem[blk_slot(t_reg, 4'd15)];
        end else if (state_reg == ST_SIG1) begin
            sig_op  = SSHA_SIG1;
            sig_rs1 = buf_mem[blk_slot(t_reg, 4'd2)];
        end
    end

    // buf[t mod 16] still holds W[t-16] here; it is overwritten with W[t]
    // at the end of the same SIG1 cycle.
    assign w_new = tmp_reg + sig_rd + buf_mem[blk_slot(t_reg, 4'd7)] + buf_mem[t_reg[3:0]];

    always_comb begin
        state_next    = state_reg;
        t_next        = t_reg;
        tmp_next      = tmp_reg;
        out_word_next = out_word_reg;
        done_next     = 1'b0;
        buf_we        = 1'b0;
        buf_waddr     = t_reg[3:0];
        buf_wdata     = bus.in_word;

        unique case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_LOAD;
                    t_next     = '0;
                end
            end

            ST_LOAD: begin
                if (bus.in_valid) begin
                    buf_we    = 1'b1;
                    buf_waddr = t_reg[3:0];
                    buf_wdata = bus.in_word;
                    if (t_reg == LAST_BLK) begin
                        // Slot 0 was written by the first load, so W[0] is ready.
                        state_next    = ST_OUT;
                        t_next        = '0;
                        out_word_next = buf_mem[4'd0];
                    end else begin
                        t_next = t_reg + 6'd1;
                    end
                end
            end

            ST_SIG0: begin
                tmp_next   = sig_rd;
                state_next = ST_SIG1;
            end

            ST_SIG1: begin
                buf_we        = 1'b1;
                buf_waddr     = t_reg[3:0];
                buf_wdata     = w_new;
                out_word_next = w_new;
                state_next    = ST_OUT;
            end

            ST_OUT: begin
                if (bus.out_ready) begin
                    if (t_reg == LAST_T) begin
                        state_next = ST_IDLE;
                        t_next     = '0;
                        done_next  = 1'b1;
                    end else if (t_reg < LAST_BLK) begin
                        t_next        = t_reg + 6'd1;
                        out_word_next = buf_mem[t_reg[3:0] + 4'd1];
                    end else begin
                        t_next     = t_reg + 6'd1;
                        state_next = ST_SIG0;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                t_next     = '0;
            end
        endcase

        // Cancel wins over any handshake or write in the same cycle.
        if (bus.abort && (state_reg != ST_IDLE)) begin
            state_next = ST_IDLE;
            t_next     = '0;
            done_next  = 1'b0;
            buf_we     = 1'b0;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            t_reg        <= '0;
            tmp_reg      <= '0;
            out_word_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            t_reg        <= t_next;
            tmp_reg      <= tmp_next;
            out_word_reg <= out_word_next;
            done_reg     <= done_next;
        end
    end

    always_ff @(posedge g_clk) begin
        if (buf_we) begin
            buf_mem[buf_waddr] <= buf_wdata;
        end
    end

    // Status outputs decode straight from the state register, so an
    // asynchronous reset clears them without waiting for a clock edge.
    assign bus.busy      = (state_reg != ST_IDLE);
    assign bus.in_ready  = (state_reg == ST_LOAD);
    assign bus.out_valid = (state_reg == ST_OUT);
    assign bus.out_word  = out_word_reg;
    assign bus.out_idx   = t_reg;
    assign bus.done      = done_reg;

endmodule

// File: tb/tb_riscv_crypto_sha256_msched.sv
// -----------------------------------------------------------------------------
// tb_riscv_crypto_sha256_msched
// Self-checking bench: a plain-arithmetic SHA-256 schedule model predicts every
// schedule word; one per-cycle compare step checks the output stream, the done
// pulse and handshake timing. Literal abc-block values pin the model.
// -----------------------------------------------------------------------------
module tb_riscv_crypto_sha256_msched;

    typedef logic [31:0] blk_t [16];

    logic g_clk = 1'b0;
    logic g_resetn = 1'b1;

    always #5 g_clk = ~g_clk;

    riscv_crypto_sha256_msched_if bus ();

    riscv_crypto_sha256_msched #(.ROUNDS(64)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .bus      (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_idx = 0;
    int hs_count = 0;
    int done_count = 0;
    int n_loads = 0;
    int first_valid_cyc = -1;
    int last_load_cyc = 0;
    int last_hs_cyc = 0;
    int done_cyc = 0;
    bit exp_active = 1'b0;
    bit done_exp = 1'b0;
    logic [31:0] exp_w [64];
    logic [31:0] got_w [64];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] s0f(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1f(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Textbook SHA-256 expansion over the whole 64-word array.
    function automatic void build_model(input blk_t blk);
        for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
        for (int i = 16; i < 64; i++)
            exp_w[i] = s1f(exp_w[i-2]) + exp_w[i-7] + s0f(exp_w[i-15]) + exp_w[i-16];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // One clock cycle: compare the stable outputs against the model, account
    // for the handshakes that the next rising edge will complete, then wait.
    task automatic step();
        cyc++;
        if (bus.out_valid) begin
            if (!exp_active) begin
                chk("spurious_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                chk("out_idx", 32'(bus.out_idx), 32'(exp_idx));
                chk($sformatf("W%0d", exp_idx), bus.out_word, exp_w[exp_idx]);
            end
        end
        chk("done", 32'(bus.done), 32'(done_exp));
        if (bus.done) begin
            done_count++;
            done_cyc = cyc;
        end
        done_exp = 1'b0;
        if (bus.in_valid && bus.in_ready) begin
            n_loads++;
            if (n_loads == 16) last_load_cyc = cyc;
        end
        if (bus.abort && bus.busy) begin
            exp_active = 1'b0;
        end else if (bus.out_valid && bus.out_ready && exp_active) begin
            hs_count++;
            got_w[exp_idx] = bus.out_word;
            if (exp_idx == 63) begin
                exp_active  = 1'b0;
                done_exp    = 1'b1;
                last_hs_cyc = cyc;
            end else begin
                exp_idx++;
            end
        end
        @(negedge g_clk);
    endtask

    task automatic load_block(input blk_t blk, input bit gaps);
        int i;
        build_model(blk);
        n_loads = 0;
        first_valid_cyc = -1;
        hs_count = 0;
        done_count = 0;
        exp_idx = 0;
        exp_active = 1'b1;
        done_exp = 1'b0;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("start_busy", 32'(bus.busy), 32'd1);
        i = 0;
        for (int n = 0; n < 400 && i < 16; n++) begin
            bit adv;
            bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.in_word  = bus.in_valid ? blk[i] : $urandom;
            adv = bus.in_valid && bus.in_ready;
            step();
            if (adv) i++;
        end
        bus.in_valid = 1'b0;
        chk("load_count", 32'(i), 32'd16);
    endtask

    // mode 0: ready held high; 1: random ready, junk in_valid, start pulses;
    // 2: stall 5 cycles at index 20; 3: abort at index 30; 4: stop in SIG1, t=40
    task automatic drain(input int mode);
        bit held = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!exp_active && !done_exp) break;
            bus.out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid  = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.in_word   = $urandom;
            bus.start     = (mode == 1) && exp_active && (exp_idx < 60) && ($urandom_range(0, 7) == 0);
            if (mode == 2 && !held && bus.out_valid && bus.out_idx == 6'd20) begin
                held = 1'b1;
                bus.out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    chk("hold_valid", 32'(bus.out_valid), 32'd1);
                    chk("hold_idx", 32'(bus.out_idx), 32'd20);
                    step();
                end
                bus.out_ready = 1'b1;
            end
            if (mode == 3 && bus.out_valid && bus.out_idx == 6'd30) begin
                bus.abort = 1'b1;
                step();
                bus.abort = 1'b0;
                chk("abort_busy", 32'(bus.busy), 32'd0);
                chk("abort_valid", 32'(bus.out_valid), 32'd0);
                step();
                step();
                return;
            end
            if (mode == 4 && exp_active && exp_idx == 40 && !bus.out_valid) begin
                step();
                return;
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        chk("drain_timeout", 32'(exp_active | done_exp), 32'd0);
    endtask

    task automatic finish_block(input string name);
        chk("word_count", 32'(hs_count), 32'd64);
        chk("done_count", 32'(done_count), 32'd1);
        $display("[TB] block %s: %0d words, %0d done pulse(s)", name, hs_count, done_count);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_out_word"}, bus.out_word, 32'd0);
        chk({tag, "_out_idx"}, 32'(bus.out_idx), 32'd0);
    endtask

    initial begin
        blk_t abc;
        blk_t zero;
        blk_t rnd;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_word = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            abc[i]  = 32'h0;
            zero[i] = 32'h0;
        end
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;

        #2 g_resetn = 1'b0;
        #1;
        chk_reset_outputs("reset");
        @(negedge g_clk);
        step();
        step();
        g_resetn = 1'b1;
        step();
        step();

        // Padded "abc" block with the consumer always ready.
        load_block(abc, 1'b0);
        drain(0);
        finish_block("abc");
        chk("model_W16", exp_w[16], 32'h61626380);
        chk("model_W17", exp_w[17], 32'h000F0000);
        chk("model_W63", exp_w[63], 32'h12B1EDEB);
        chk("dut_W16", got_w[16], 32'h61626380);
        chk("dut_W17", got_w[17], 32'h000F0000);
        chk("dut_W63", got_w[63], 32'h12B1EDEB);
        chk("first_valid_lat", 32'(first_valid_cyc - last_load_cyc), 32'd1);
        // 16 single-cycle words, then 48 words at 3 cycles each: the last
        // handshake sits in cycle 159 counting the first valid cycle as 0.
        chk("last_hs_dist", 32'(last_hs_cyc - first_valid_cyc), 32'd159);
        chk("done_after_last", 32'(done_cyc - last_hs_cyc), 32'd1);

        // Random blocks with back-pressure, ignored in_valid and start pulses.
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 16; i++) rnd[i] = $urandom;
            load_block(rnd, 1'b1);
            drain(1);
            finish_block("random");
        end

        // Stall while index 20 is presented.
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        load_block(rnd, 1'b0);
        drain(2);
        finish_block("stall");

        // Abort with a simultaneous accept, then an all-zero block.
        for (int i = 0; i < 16; i++) rnd[i] = $urandom;
        load_block(rnd, 1'b1);
        drain(3);
        chk("abort_words", 32'(hs_count), 32'd30);
        chk("abort_no_done", 32'(done_count), 32'd0);
        $display("[TB] block abort: %0d words before cancel", hs_count);
        load_block(zero, 1'b0);
        drain(0);
        finish_block("zero");
        chk("zero_W63", got_w[63], 32'h0);

        // Asynchronous reset during SIG1 of W[40].
        load_block(abc, 1'b0);
        drain(4);
        chk("pre_reset_busy", 32'(bus.busy), 32'd1);
        chk("pre_reset_valid", 32'(bus.out_valid), 32'd0);
        #1 g_resetn = 1'b0;
        exp_active = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        $display("[TB] block reset: cancelled after %0d words", hs_count);
        step();
        step();
        g_resetn = 1'b1;
        step();
        step();
        step();
        load_block(abc, 1'b0);
        drain(0);
        finish_block("abc_after_reset");
        chk("rst_W16", got_w[16], 32'h61626380);
        chk("rst_W17", got_w[17], 32'h000F0000);
        chk("rst_W63", got_w[63], 32'h12B1EDEB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
